// File: rtl/ram_port_arbiter.sv
// Arbiter sharing one single-port RAM between the CPU (read/write) and the readout unit (read-only).
// Combinational req/gnt with starvation escape; a one-deep return FSM routes read data to its owner.
module ram_port_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_rvalid,
    output logic [DATA_W-1:0] rd_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        RET_CPU,
        RET_RD
    } ret_state_e;

    ret_state_e        state_q,    state_d;
    logic [CNT_W-1:0]  starve_q,   starve_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] din_q,      din_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
    logic [DATA_W-1:0] rd_hold_q,  rd_hold_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cpu_gnt = 1'b0;
        rd_gnt  = 1'b0;
        if (!reset) begin
            if (rd_req && (starve_q == STARVE_LIM || !cpu_req)) begin
                rd_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    // Address/data registers only move on a grant, so the RAM pins stay quiet while idle.
    always_comb begin
        addr_d = addr_q;
        din_d  = din_q;
        if (cpu_gnt) begin
            addr_d = cpu_addr;
            if (cpu_we) begin
                din_d = cpu_wdata;
            end
        end else if (rd_gnt) begin
            addr_d = rd_addr;
        end
        if (reset) begin
            addr_d = '0;
            din_d  = '0;
        end
        ram_en   = cpu_gnt | rd_gnt;
        ram_we   = cpu_gnt & cpu_we;
        ram_addr = addr_d;
        ram_din  = din_d;
    end

    always_comb begin
        starve_d = starve_q;
        if (reset || !rd_req || rd_gnt) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Grants are already forced low in reset, so a read issued then never reaches a RET state.
    always_comb begin
        state_d = IDLE;
        if (cpu_gnt && !cpu_we) begin
            state_d = RET_CPU;
        end else if (rd_gnt) begin
            state_d = RET_RD;
        end
    end

    always_comb begin
        cpu_rvalid = !reset && (state_q == RET_CPU);
        rd_rvalid  = !reset && (state_q == RET_RD);
        cpu_hold_d = cpu_rvalid ? ram_dout : cpu_hold_q;
        rd_hold_d  = rd_rvalid  ? ram_dout : rd_hold_q;
        if (reset) begin
            cpu_hold_d = '0;
            rd_hold_d  = '0;
        end
        cpu_rdata = cpu_hold_d;
        rd_rdata  = rd_hold_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        state_q    <= state_d;
        starve_q   <= starve_d;
        addr_q     <= addr_d;
        din_q      <= din_d;
        cpu_hold_q <= cpu_hold_d;
        rd_hold_q  <= rd_hold_d;
    end

    a_one_grant: assert property (@(posedge clk) !(cpu_gnt && rd_gnt));
    a_we_cpu_only: assert property (@(posedge clk) ram_we |-> cpu_gnt);
    a_starve_bound: assert property (@(posedge clk) starve_q <= STARVE_LIM);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed stimulus pushes expected returns, a monitor pops them.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, rd_req;
    logic [5:0]  cpu_addr, rd_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid, rd_gnt, rd_rvalid;
    logic [15:0] cpu_rdata, rd_rdata;
    logic        ram_en, ram_we;
    logic [5:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout = '0;

    logic [15:0] mem [64];
    logic [15:0] cpu_exp_q[$];
    logic [15:0] rd_exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    ram_port_arbiter #(.ADDR_W(6), .DATA_W(16), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port RAM model, 1-cycle read latency; unwritten word i reads 0xA000+i.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_gnt"},    32'(cpu_gnt),    0);
        check({tag, "_rd_gnt"},     32'(rd_gnt),     0);
        check({tag, "_ram_en"},     32'(ram_en),     0);
        check({tag, "_ram_we"},     32'(ram_we),     0);
        check({tag, "_ram_addr"},   32'(ram_addr),   0);
        check({tag, "_ram_din"},    32'(ram_din),    0);
        check({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 0);
        check({tag, "_rd_rvalid"},  32'(rd_rvalid),  0);
        check({tag, "_cpu_rdata"},  32'(cpu_rdata),  0);
        check({tag, "_rd_rdata"},   32'(rd_rdata),   0);
    endtask

    // Monitor: every rvalid must match the oldest expected return for that port.
    initial begin
        forever begin
            @(negedge clk);
            if (cpu_rvalid) begin
                if (cpu_exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL cpu_unexpected_rvalid: got rdata 0x%0h, expected no return", cpu_rdata);
                end else begin
                    check("cpu_return", 32'(cpu_rdata), 32'(cpu_exp_q.pop_front()));
                end
            end
            if (rd_rvalid) begin
                if (rd_exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rd_unexpected_rvalid: got rdata 0x%0h, expected no return", rd_rdata);
                end else begin
                    check("rd_return", 32'(rd_rdata), 32'(rd_exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
        reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; rd_req = 0; rd_addr = 0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_reset_outputs("por");
        next_cycle();
        reset = 1'b0;

        // 1: CPU write 0x1234 @5 then read @5
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'd5; cpu_wdata = 16'h1234;
        @(negedge clk);
        check("t1_wr_gnt", 32'(cpu_gnt), 1);
        check("t1_wr_ram_we", 32'(ram_we), 1);
        check("t1_wr_ram_addr", 32'(ram_addr), 5);
        check("t1_wr_ram_din", 32'(ram_din), 'h1234);
        check("t1_wr_rd_gnt", 32'(rd_gnt), 0);
        next_cycle();
        cpu_we = 0; cpu_wdata = 0;
        @(negedge clk);
        check("t1_rd_gnt", 32'(cpu_gnt), 1);
        check("t1_rd_ram_we", 32'(ram_we), 0);
        check("t1_rd_ram_en", 32'(ram_en), 1);
        cpu_exp_q.push_back(16'h1234);
        next_cycle();
        cpu_req = 0;
        @(negedge clk);
        check("t1_idle_en", 32'(ram_en), 0);
        check("t1_rvalid", 32'(cpu_rvalid), 1);
        next_cycle();

        // 2: readout alone @3
        rd_req = 1; rd_addr = 6'd3;
        @(negedge clk);
        check("t2_rd_gnt", 32'(rd_gnt), 1);
        check("t2_cpu_gnt", 32'(cpu_gnt), 0);
        check("t2_ram_we", 32'(ram_we), 0);
        check("t2_ram_addr", 32'(ram_addr), 3);
        rd_exp_q.push_back(16'hA003);
        next_cycle();
        rd_req = 0;
        @(negedge clk);
        check("t2_rd_rvalid", 32'(rd_rvalid), 1);
        check("t2_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("t2_cpu_rdata_hold", 32'(cpu_rdata), 'h1234);
        next_cycle();

        // 3: both requesting for 20 cycles; readout wins on the 9th and 18th
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'd10; cpu_wdata = 16'hBEEF;
        rd_req = 1; rd_addr = 6'd4;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("t3_rd_gnt_%0d", k), 32'(rd_gnt), 32'((k == 8) || (k == 17)));
            check($sformatf("t3_cpu_gnt_%0d", k), 32'(cpu_gnt), 32'(!((k == 8) || (k == 17))));
            if (k == 8 || k == 17) rd_exp_q.push_back(16'hA004);
            next_cycle();
        end
        cpu_req = 0; cpu_we = 0; cpu_wdata = 0; rd_req = 0;
        next_cycle();

        // 4: alternating CPU read @1 and readout read @2
        for (int k = 0; k < 8; k++) begin
            cpu_req = (k % 2 == 0); cpu_we = 0; cpu_addr = 6'd1;
            rd_req = (k % 2 == 1); rd_addr = 6'd2;
            @(negedge clk);
            check($sformatf("t4_cpu_gnt_%0d", k), 32'(cpu_gnt), 32'(k % 2 == 0));
            check($sformatf("t4_rd_gnt_%0d", k), 32'(rd_gnt), 32'(k % 2 == 1));
            if (k % 2 == 0) cpu_exp_q.push_back(16'hA001);
            else            rd_exp_q.push_back(16'hA002);
            next_cycle();
        end
        cpu_req = 0; rd_req = 0;
        next_cycle();
        next_cycle();

        // 5: reset in the cycle after a readout grant
        rd_req = 1; rd_addr = 6'd7;
        @(negedge clk);
        check("t5_rd_gnt", 32'(rd_gnt), 1);
        next_cycle();
        rd_req = 0; reset = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'd5;
        @(negedge clk);
        check_reset_outputs("t5_rst1");
        next_cycle();
        @(negedge clk);
        check_reset_outputs("t5_rst2");
        next_cycle();
        reset = 0;
        @(negedge clk);
        check("t5_first_gnt", 32'(cpu_gnt), 1);
        check("t5_first_addr", 32'(ram_addr), 5);
        cpu_exp_q.push_back(16'h1234);
        next_cycle();
        cpu_req = 0; rd_req = 1; rd_addr = 6'd2;
        @(negedge clk);
        check("t5_rd_gnt2", 32'(rd_gnt), 1);
        rd_exp_q.push_back(16'hA002);
        next_cycle();
        rd_req = 0;

        // 6: ten idle cycles, RAM pins and hold registers stay put
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("t6_ram_en_%0d", k), 32'(ram_en), 0);
            check($sformatf("t6_ram_addr_%0d", k), 32'(ram_addr), 2);
            check($sformatf("t6_ram_din_%0d", k), 32'(ram_din), 0);
            check($sformatf("t6_cpu_rdata_%0d", k), 32'(cpu_rdata), 'h1234);
            check($sformatf("t6_rd_rdata_%0d", k), 32'(rd_rdata), 'hA002);
            next_cycle();
        end

        check("cpu_returns_drained", 32'(cpu_exp_q.size()), 0);
        check("rd_returns_drained", 32'(rd_exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
